// File: rtl/mac_seq_ctrl_if.sv
// Handshake and RAM/MAC control bundle between the batch sequencer and its datapath.
interface mac_seq_ctrl_if;
  localparam int unsigned NV_W  = 4;
  localparam int unsigned CNT_W = 11;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned SEL_W = 2;

  logic             start;
  logic [NV_W-1:0]  num_vec;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] clock_count;
  logic [IDX_W-1:0] idx_a;
  logic [IDX_W-1:0] idx_b;
  logic             mac_en;
  logic             macc_clear;
  logic             we_c;
  logic [IDX_W-1:0] idx_c1;
  logic [IDX_W-1:0] idx_c2;
  logic [SEL_W-1:0] sel_c;

  modport master (
    output start, num_vec,
    input  busy, done, err, clock_count, idx_a, idx_b, mac_en, macc_clear,
           we_c, idx_c1, idx_c2, sel_c
  );

  modport slave (
    input  start, num_vec,
    output busy, done, err, clock_count, idx_a, idx_b, mac_en, macc_clear,
           we_c, idx_c1, idx_c2, sel_c
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Batch sequencer for an 8-lane MAC: per vector, 8 issue cycles, 1 drain cycle, 4 result-write cycles.
module mac_seq_ctrl (
  input  logic           clk,
  input  logic           reset,
  mac_seq_ctrl_if.slave  bus
);
  localparam int unsigned NV_W  = 4;
  localparam int unsigned CNT_W = 11;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned K_W   = 3;
  localparam int unsigned J_W   = 2;
  localparam int unsigned MAX_V = 8;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

  state_t           state_q, state_n;
  logic [K_W-1:0]   k_q, k_n;
  logic [J_W-1:0]   j_q, j_n;
  logic [K_W-1:0]   vec_q, vec_n;
  logic [NV_W-1:0]  nvec_q, nvec_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             err_q, err_n;
  logic             mac_en_q, mac_en_n;
  logic             clr_q, clr_n;
  logic             we_q, we_n;
  logic [IDX_W-1:0] idx_a_q, idx_a_n;
  logic [IDX_W-1:0] idx_b_q, idx_b_n;
  logic [IDX_W-1:0] idx_c1_q, idx_c1_n;
  logic [IDX_W-1:0] idx_c2_q, idx_c2_n;
  logic [J_W-1:0]   sel_q, sel_n;

  // State and registered outputs; outputs are computed from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      j_q      <= '0;
      vec_q    <= '0;
      nvec_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mac_en_q <= 1'b0;
      clr_q    <= 1'b0;
      we_q     <= 1'b0;
      idx_a_q  <= '0;
      idx_b_q  <= '0;
      idx_c1_q <= '0;
      idx_c2_q <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_n;
      k_q      <= k_n;
      j_q      <= j_n;
      vec_q    <= vec_n;
      nvec_q   <= nvec_n;
      cnt_q    <= cnt_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      err_q    <= err_n;
      mac_en_q <= mac_en_n;
      clr_q    <= clr_n;
      we_q     <= we_n;
      idx_a_q  <= idx_a_n;
      idx_b_q  <= idx_b_n;
      idx_c1_q <= idx_c1_n;
      idx_c2_q <= idx_c2_n;
      sel_q    <= sel_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    k_n      = k_q;
    j_n      = j_q;
    vec_n    = vec_q;
    nvec_n   = nvec_q;
    cnt_n    = cnt_q;
    err_n    = 1'b0;
    idx_a_n  = idx_a_q;
    idx_b_n  = idx_b_q;
    idx_c1_n = idx_c1_q;
    idx_c2_n = idx_c2_q;
    sel_n    = sel_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if ((bus.num_vec != '0) && (bus.num_vec <= NV_W'(MAX_V))) begin
            state_n = ISSUE;
            nvec_n  = bus.num_vec;
            vec_n   = '0;
            k_n     = '0;
            cnt_n   = CNT_W'(1);
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (k_q == K_W'(7)) begin
          state_n = DRAIN;
        end else begin
          k_n = k_q + K_W'(1);
        end
      end
      DRAIN: begin
        cnt_n   = cnt_q + CNT_W'(1);
        state_n = WRITE;
        j_n     = '0;
      end
      WRITE: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (j_q == J_W'(3)) begin
          if (NV_W'(vec_q) < (nvec_q - NV_W'(1))) begin
            state_n = ISSUE;
            vec_n   = vec_q + K_W'(1);
            k_n     = '0;
          end else begin
            state_n = DONE;
          end
        end else begin
          j_n = j_q + J_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n   = (state_n != IDLE);
    done_n   = (state_n == DONE);
    we_n     = (state_n == WRITE);
    // Operand data trails the address by one cycle, so the MAC lags issue by one cycle.
    mac_en_n = ((state_n == ISSUE) && (k_n != '0)) || (state_n == DRAIN);
    clr_n    = (state_n == ISSUE) && (k_n == K_W'(1));

    if (state_n == ISSUE) begin
      idx_a_n = {k_n, 3'b000};
      idx_b_n = {vec_n, k_n};
    end
    if (state_n == WRITE) begin
      sel_n    = j_n;
      idx_c1_n = {vec_n, j_n, 1'b0};
      idx_c2_n = {vec_n, j_n, 1'b1};
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.clock_count = cnt_q;
  assign bus.idx_a       = idx_a_q;
  assign bus.idx_b       = idx_b_q;
  assign bus.mac_en      = mac_en_q;
  assign bus.macc_clear  = clr_q;
  assign bus.we_c        = we_q;
  assign bus.idx_c1      = idx_c1_q;
  assign bus.idx_c2      = idx_c2_q;
  assign bus.sel_c       = sel_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural RAM/MAC datapath model.
module tb_mac_seq_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic clr_c;

  always #5 clk = ~clk;

  mac_seq_ctrl_if bus ();

  mac_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        mac_en;
    logic        macc_clear;
    logic        we_c;
    logic [5:0]  idx_a;
    logic [5:0]  idx_b;
    logic [5:0]  idx_c1;
    logic [5:0]  idx_c2;
    logic [1:0]  sel_c;
    logic [10:0] clock_count;
  } out_t;

  int checks   = 0;
  int failures = 0;

  int ram_a [64];
  int ram_b [64];
  int ram_c [64];
  int a_q   [8];
  int b_q;
  int lane  [8];

  // Datapath model: 1-cycle RAM reads, 8 MAC lanes, dual-port result writes.
  always @(posedge clk) begin
    for (int l = 0; l < 8; l++) a_q[l] <= ram_a[(int'(bus.idx_a) + l) & 63];
    b_q <= ram_b[int'(bus.idx_b)];
    if (bus.mac_en) begin
      for (int l = 0; l < 8; l++)
        lane[l] <= bus.macc_clear ? a_q[l] * b_q : lane[l] + a_q[l] * b_q;
    end
    if (clr_c) begin
      for (int i = 0; i < 64; i++) ram_c[i] <= -1;
    end else if (bus.we_c) begin
      ram_c[int'(bus.idx_c1)] <= lane[2 * int'(bus.sel_c)];
      ram_c[int'(bus.idx_c2)] <= lane[2 * int'(bus.sel_c) + 1];
    end
  end

  function automatic out_t mk(input logic busy, input logic done, input logic mac,
                              input logic clr, input logic we, input int a, input int b,
                              input int c1, input int c2, input int sel, input int cc);
    out_t o;
    o.busy = busy; o.done = done; o.err = 1'b0; o.mac_en = mac; o.macc_clear = clr;
    o.we_c = we; o.idx_a = 6'(a); o.idx_b = 6'(b); o.idx_c1 = 6'(c1); o.idx_c2 = 6'(c2);
    o.sel_c = 2'(sel); o.clock_count = 11'(cc);
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.busy = bus.busy; o.done = bus.done; o.err = bus.err; o.mac_en = bus.mac_en;
    o.macc_clear = bus.macc_clear; o.we_c = bus.we_c; o.idx_a = bus.idx_a;
    o.idx_b = bus.idx_b; o.idx_c1 = bus.idx_c1; o.idx_c2 = bus.idx_c2;
    o.sel_c = bus.sel_c; o.clock_count = bus.clock_count;
    return o;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input out_t exp);
    out_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of run cycle 1.
  task automatic pulse_start(input int n);
    bus.start   = 1'b1;
    bus.num_vec = 4'(n);
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // Watches a run from cycle 1; optionally re-asserts start during cycle `inject`.
  task automatic run_watch(input int limit, input int inject, output int done_cyc,
                           output int errs, output int last_c1, output int last_c2);
    done_cyc = 0; errs = 0; last_c1 = -1; last_c2 = -1;
    for (int c = 1; c <= limit && done_cyc == 0; c++) begin
      if (bus.err) errs++;
      if (bus.we_c) begin
        last_c1 = int'(bus.idx_c1);
        last_c2 = int'(bus.idx_c2);
      end
      if (bus.done) done_cyc = c;
      bus.start = (c == inject);
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (done_cyc == 0) begin
      failures++;
      $display("FAIL run_timeout: got no done expected done within %0d cycles", limit);
    end
  endtask

  out_t tbl [14];
  int   dcyc, errs, c1, c2, seen;
  int   bad_nv [3];

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1);
    tbl[1]  = mk(1, 0, 1, 1, 0,  8, 1, 0, 0, 0,  2);
    tbl[2]  = mk(1, 0, 1, 0, 0, 16, 2, 0, 0, 0,  3);
    tbl[3]  = mk(1, 0, 1, 0, 0, 24, 3, 0, 0, 0,  4);
    tbl[4]  = mk(1, 0, 1, 0, 0, 32, 4, 0, 0, 0,  5);
    tbl[5]  = mk(1, 0, 1, 0, 0, 40, 5, 0, 0, 0,  6);
    tbl[6]  = mk(1, 0, 1, 0, 0, 48, 6, 0, 0, 0,  7);
    tbl[7]  = mk(1, 0, 1, 0, 0, 56, 7, 0, 0, 0,  8);
    tbl[8]  = mk(1, 0, 1, 0, 0, 56, 7, 0, 0, 0,  9);
    tbl[9]  = mk(1, 0, 0, 0, 1, 56, 7, 0, 1, 0, 10);
    tbl[10] = mk(1, 0, 0, 0, 1, 56, 7, 2, 3, 1, 11);
    tbl[11] = mk(1, 0, 0, 0, 1, 56, 7, 4, 5, 2, 12);
    tbl[12] = mk(1, 0, 0, 0, 1, 56, 7, 6, 7, 3, 13);
    tbl[13] = mk(1, 1, 0, 0, 0, 56, 7, 6, 7, 3, 14);
    bad_nv[0] = 0; bad_nv[1] = 9; bad_nv[2] = 15;

    for (int i = 0; i < 64; i++) begin
      ram_a[i] = ((i / 8) == (i % 8)) ? 1 : 0;
      ram_b[i] = i;
    end

    reset = 1'b1; clr_c = 1'b0; bus.start = 1'b0; bus.num_vec = '0;
    repeat (2) @(negedge clk);
    check_out("reset_state", '0);

    // Reset wins over a simultaneous start.
    bus.start = 1'b1; bus.num_vec = 4'd1;
    @(negedge clk);
    bus.start = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("reset_priority_busy", int'(bus.busy), 0);

    // Single vector, cycle-by-cycle against the table.
    pulse_start(1);
    for (int c = 0; c < 14; c++) begin
      check_out($sformatf("single_cycle%0d", c + 1), tbl[c]);
      @(negedge clk);
    end
    check_out("single_idle_hold", mk(0, 0, 0, 0, 0, 56, 7, 6, 7, 3, 14));

    // Full batch through the datapath model: identity A times B=0..63.
    clr_c = 1'b1;
    @(negedge clk);
    clr_c = 1'b0;
    pulse_start(8);
    run_watch(150, 0, dcyc, errs, c1, c2);
    check("batch_done_cycle", dcyc, 105);
    check("batch_clock_count", int'(bus.clock_count), 105);
    check("batch_last_c1", c1, 62);
    check("batch_last_c2", c2, 63);
    check("batch_busy_after", int'(bus.busy), 0);
    for (int i = 0; i < 64; i++) check($sformatf("ram_c[%0d]", i), ram_c[i], i);

    // Illegal lengths: err pulse only, counter holds.
    for (int t = 0; t < 3; t++) begin
      bus.start = 1'b1; bus.num_vec = 4'(bad_nv[t]);
      @(negedge clk);
      bus.start = 1'b0;
      check($sformatf("illegal%0d_err", bad_nv[t]), int'(bus.err), 1);
      check($sformatf("illegal%0d_busy", bad_nv[t]), int'(bus.busy), 0);
      check($sformatf("illegal%0d_count", bad_nv[t]), int'(bus.clock_count), 105);
      @(negedge clk);
      check($sformatf("illegal%0d_err_drop", bad_nv[t]), int'(bus.err), 0);
    end

    // Start while busy is ignored.
    pulse_start(2);
    run_watch(150, 5, dcyc, errs, c1, c2);
    check("busy_start_done_cycle", dcyc, 27);
    check("busy_start_errs", errs, 0);
    check("busy_start_count", int'(bus.clock_count), 27);

    // Reset in cycle 11 of a 3-vector run.
    pulse_start(3);
    repeat (10) @(negedge clk);
    check("midrun_we_before_reset", int'(bus.we_c), 1);
    reset = 1'b1;
    @(negedge clk);
    check_out("midrun_reset_outputs", '0);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done || bus.we_c || bus.busy) seen++;
      @(negedge clk);
    end
    check("midrun_no_activity", seen, 0);
    pulse_start(1);
    run_watch(50, 0, dcyc, errs, c1, c2);
    check("post_reset_done_cycle", dcyc, 14);
    check("post_reset_count", int'(bus.clock_count), 14);
    check("post_reset_last_c2", c2, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
